pio_led_out: RTL and testbench



---
 rtl/pio_led_out.sv | 143 ++++++++++++++
 tb/tb_pio_led_out.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_led_out.sv
// Avalon-MM output PIO for board LEDs with set/clear aliases and registered reads.
// Optional per-bit blink engine enabled by defining PIO_LED_OUT_BLINK_EN.
module pio_led_out #(
    parameter int                  WIDTH        = 8,
    parameter logic [WIDTH-1:0]    RESET_VALUE  = '0,
    parameter int                  PERIOD_W     = 24,
    parameter logic [PERIOD_W-1:0] RESET_PERIOD = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_BLINK  = 3'd1;
    localparam logic [2:0] A_PERIOD = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;
    localparam logic [2:0] A_SET    = 3'd4;
    localparam logic [2:0] A_CLR    = 3'd5;

    logic             wr_en;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_q, data_d;
    logic [31:0]      rd_q, rd_d;
    logic             unused_wd;

    assign wr_en     = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign readdata  = rd_q;
    assign unused_wd = ^writedata;

    // Output register update: plain write, atomic set and atomic clear.
    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            case (address)
                A_DATA:  data_d = wd;
                A_SET:   data_d = data_q | wd;
                A_CLR:   data_d = data_q & ~wd;
                default: data_d = data_q;
            endcase
        end
    end

`ifdef PIO_LED_OUT_BLINK_EN
    localparam logic [PERIOD_W-1:0] P_ONE = PERIOD_W'(1);

    logic [WIDTH-1:0]    blink_q, blink_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                phase_q, phase_d;
    logic                period_wr;
    logic [1:0]          status;

    assign period_wr = wr_en && (address == A_PERIOD);
    assign status    = {period_q != '0, phase_q};

    // Blink mask and half-period register writes.
    always_comb begin
        blink_d  = blink_q;
        period_d = period_q;
        if (wr_en && (address == A_BLINK)) begin
            blink_d = wd;
        end
        if (period_wr) begin
            period_d = writedata[PERIOD_W-1:0];
        end
    end

    // Half-period counter; a PERIOD write restarts the phase and beats a wrap.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (period_wr || (period_q == '0)) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == period_q - P_ONE) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + P_ONE;
        end
    end

    // Blinking bits show DATA only during the high phase.
    assign out_port = data_q & ~(blink_q & {WIDTH{~phase_q}});

    // Read mux, captured every cycle regardless of chipselect.
    always_comb begin
        rd_d = '0;
        case (address)
            A_DATA:   rd_d[WIDTH-1:0]    = data_q;
            A_BLINK:  rd_d[WIDTH-1:0]    = blink_q;
            A_PERIOD: rd_d[PERIOD_W-1:0] = period_q;
            A_STATUS: rd_d[1:0]          = status;
            default:  rd_d               = '0;
        endcase
    end

    // Blink engine state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_q  <= '0;
            period_q <= RESET_PERIOD;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
        end else begin
            blink_q  <= blink_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
        end
    end
`else
    assign out_port = data_q;

    // Read mux, captured every cycle regardless of chipselect.
    always_comb begin
        rd_d = '0;
        case (address)
            A_DATA:  rd_d[WIDTH-1:0] = data_q;
            default: rd_d            = '0;
        endcase
    end
`endif

    // Output data and registered read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
            rd_q   <= '0;
        end else begin
            data_q <= data_d;
            rd_q   <= rd_d;
        end
    end

endmodule

// File: tb/tb_pio_led_out.sv
// Self-checking bench for pio_led_out with a cycle-indexed reference model.
// Blink expectations apply only when PIO_LED_OUT_BLINK_EN is defined.
module tb_pio_led_out;

    localparam logic [7:0] RV = 8'hA5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int total = 0;
    int bad = 0;
    int edge_cnt = 0;

    logic [7:0]  m_data = RV;
    logic [7:0]  m_blink = 8'd0;
    logic [23:0] m_period = 24'd0;
    int          m_start = 0;

    pio_led_out #(
        .WIDTH(8),
        .RESET_VALUE(RV),
        .PERIOD_W(24),
        .RESET_PERIOD(24'd0)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .out_port(out_port)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    // Phase follows from whole half-periods elapsed since the PERIOD write.
    function automatic logic m_phase();
        if (m_period == 24'd0) return 1'b0;
        return 1'(((edge_cnt - m_start) / int'(m_period)) % 2);
    endfunction

    function automatic logic [7:0] exp_out();
`ifdef PIO_LED_OUT_BLINK_EN
        logic [7:0] r;
        r = m_data;
        for (int i = 0; i < 8; i++)
            if (m_blink[i]) r[i] = m_data[i] & m_phase();
        return r;
`else
        return m_data;
`endif
    endfunction

    function automatic logic [31:0] exp_rd(input logic [2:0] a);
        case (a)
            3'd0: return {24'd0, m_data};
`ifdef PIO_LED_OUT_BLINK_EN
            3'd1: return {24'd0, m_blink};
            3'd2: return {8'd0, m_period};
            3'd3: return {30'd0, m_period != 24'd0, m_phase()};
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_data   = RV;
        m_blink  = 8'd0;
        m_period = 24'd0;
        m_start  = 0;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        int e;
        e = edge_cnt + 1;
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        case (a)
            3'd0: m_data = d[7:0];
            3'd4: m_data = m_data | d[7:0];
            3'd5: m_data = m_data & ~d[7:0];
`ifdef PIO_LED_OUT_BLINK_EN
            3'd1: m_blink = d[7:0];
            3'd2: begin
                m_period = d[23:0];
                m_start  = e;
            end
`endif
            default: ;
        endcase
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] v);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
        v = readdata;
        chipselect = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v, e;
        repeat (2) @(negedge clk);
        total++;
        if (out_port !== RV) begin
            bad++;
            $display("FAIL reset_out got %h want %h", out_port, RV);
        end
        total++;
        if (readdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_rd got %h want 0", readdata);
        end
        reset_n = 1'b1;
        e = 32'h0000_00A5;
        bus_rd(3'd0, v);
        total++;
        if (v !== e) begin
            bad++;
            $display("FAIL reset_rd0 got %h want %h", v, e);
        end
    endtask

    task automatic test_data_ops();
        logic [31:0] v;
        logic [7:0]  want [3];
        logic [2:0]  ad [3];
        logic [31:0] dt [3];
        want = '{8'h0F, 8'hFF, 8'hC3};
        ad   = '{3'd0, 3'd4, 3'd5};
        dt   = '{32'h0F, 32'hF0, 32'h3C};
        for (int i = 0; i < 3; i++) begin
            bus_wr(ad[i], dt[i]);
            total++;
            if (out_port !== want[i]) begin
                bad++;
                $display("FAIL data_op%0d got %h want %h", i, out_port, want[i]);
            end
        end
        for (int a = 4; a < 6; a++) begin
            bus_rd(3'(a), v);
            total++;
            if (v !== 32'd0) begin
                bad++;
                $display("FAIL rd_alias%0d got %h want 0", a, v);
            end
        end
    endtask

    task automatic test_random_data();
        logic [31:0] v, e, d;
        logic [2:0]  a;
        int          k;
        for (int i = 0; i < 24; i++) begin
            k = int'($urandom_range(0, 2));
            a = (k == 0) ? 3'd0 : (k == 1) ? 3'd4 : 3'd5;
            d = $urandom;
            bus_wr(a, d);
            total++;
            if (out_port !== exp_out()) begin
                bad++;
                $display("FAIL rnd_out got %h want %h", out_port, exp_out());
            end
            e = exp_rd(3'd0);
            bus_rd(3'd0, v);
            total++;
            if (v !== e) begin
                bad++;
                $display("FAIL rnd_rd0 got %h want %h", v, e);
            end
        end
    endtask

`ifdef PIO_LED_OUT_BLINK_EN
    task automatic test_blink();
        logic [15:0] seq;
        logic [31:0] v, e;
        bus_wr(3'd1, 32'h01);
        bus_wr(3'd0, 32'h01);
        bus_wr(3'd2, 32'd4);
        for (int i = 0; i < 16; i++) begin
            seq[15-i] = out_port[0];
            total++;
            if (out_port !== exp_out()) begin
                bad++;
                $display("FAIL blink_out got %h want %h", out_port, exp_out());
            end
            @(negedge clk);
        end
        total++;
        if (seq !== 16'b0000111100001111) begin
            bad++;
            $display("FAIL blink_seq got %b want 0000111100001111", seq);
        end
        e = exp_rd(3'd3);
        bus_rd(3'd3, v);
        total++;
        if (v !== e || v[1] !== 1'b1) begin
            bad++;
            $display("FAIL blink_status got %h want %h", v, e);
        end
        for (int r = 0; r < 3; r++) begin
            bus_wr(3'd1, $urandom);
            bus_wr(3'd0, $urandom);
            bus_wr(3'd2, $urandom_range(1, 5));
            for (int i = 0; i < 12; i++) begin
                total++;
                if (out_port !== exp_out()) begin
                    bad++;
                    $display("FAIL rblink_out got %h want %h", out_port, exp_out());
                end
                @(negedge clk);
            end
            e = exp_rd(3'd3);
            bus_rd(3'd3, v);
            total++;
            if (v !== e) begin
                bad++;
                $display("FAIL rblink_status got %h want %h", v, e);
            end
        end
    endtask

    task automatic test_period_rewrite();
        logic [7:0]  seq;
        logic [31:0] v, e;
        bit          found;
        bus_wr(3'd1, 32'h01);
        bus_wr(3'd0, 32'h01);
        bus_wr(3'd2, 32'd4);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if ((edge_cnt - m_start) % 8 == 3) found = 1'b1;
            else @(negedge clk);
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL rewrite_sync got 0 want 1");
        end
        bus_wr(3'd2, 32'd2);
        e = exp_rd(3'd3);
        for (int i = 0; i < 8; i++) begin
            seq[7-i] = out_port[0];
            @(negedge clk);
        end
        total++;
        if (seq !== 8'b00110011) begin
            bad++;
            $display("FAIL rewrite_seq got %b want 00110011", seq);
        end
        total++;
        if (e[0] !== 1'b0) begin
            bad++;
            $display("FAIL rewrite_model got %h want phase 0", e);
        end
        bus_wr(3'd2, 32'd0);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (out_port[0] !== 1'b0) begin
                bad++;
                $display("FAIL halt_out got %b want 0", out_port[0]);
            end
            @(negedge clk);
        end
        bus_rd(3'd3, v);
        total++;
        if (v !== 32'd0) begin
            bad++;
            $display("FAIL halt_status got %h want 0", v);
        end
    endtask
`else
    task automatic test_no_blink();
        logic [31:0] v;
        bus_wr(3'd1, 32'hFF);
        bus_wr(3'd2, 32'd4);
        bus_wr(3'd3, 32'hFF);
        for (int a = 1; a < 4; a++) begin
            bus_rd(3'(a), v);
            total++;
            if (v !== 32'd0) begin
                bad++;
                $display("FAIL nob_rd%0d got %h want 0", a, v);
            end
        end
        bus_wr(3'd0, 32'h5A);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (out_port !== 8'h5A) begin
                bad++;
                $display("FAIL nob_out got %h want 5a", out_port);
            end
            @(negedge clk);
        end
    endtask
`endif

    task automatic test_width_reserved();
        logic [31:0] v, e;
        bus_wr(3'd0, 32'hFFFF_FFFF);
        bus_rd(3'd0, v);
        total++;
        if (v !== 32'h0000_00FF) begin
            bad++;
            $display("FAIL width_rd0 got %h want 000000ff", v);
        end
        bus_wr(3'd0, 32'h96);
        bus_wr(3'd6, 32'hFFFF_FFFF);
        for (int a = 0; a < 8; a++) begin
            e = exp_rd(3'(a));
            bus_rd(3'(a), v);
            total++;
            if (v !== e) begin
                bad++;
                $display("FAIL resv_rd%0d got %h want %h", a, v, e);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] v, e;
        bus_wr(3'd1, 32'hFF);
        bus_wr(3'd0, 32'hFF);
        bus_wr(3'd2, 32'd3);
        repeat (5) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (out_port !== RV) begin
            bad++;
            $display("FAIL arst_out got %h want %h", out_port, RV);
        end
        total++;
        if (readdata !== 32'd0) begin
            bad++;
            $display("FAIL arst_rd got %h want 0", readdata);
        end
        m_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            e = exp_rd(3'(a));
            bus_rd(3'(a), v);
            total++;
            if (v !== e) begin
                bad++;
                $display("FAIL arst_reg%0d got %h want %h", a, v, e);
            end
        end
        total++;
        if (out_port !== RV) begin
            bad++;
            $display("FAIL arst_hold got %h want %h", out_port, RV);
        end
    endtask

    initial begin
        test_reset();
        test_data_ops();
        test_random_data();
`ifdef PIO_LED_OUT_BLINK_EN
        test_blink();
        test_period_rewrite();
`else
        test_no_blink();
`endif
        test_width_reserved();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
